fact_accel: RTL and testbench

//   Memory-mapped factorial accelerator on the processor's data-memory bus, downstream of the

---
 rtl/fact_accel_if.sv | 33 +++
 rtl/fact_accel.sv | 143 ++++++++++++++
 tb/tb_fact_accel.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fact_accel_if.sv
// Data-memory bus slice seen by the factorial accelerator.
//
// Bus protocol: there is no valid/ready pair on this bus. The processor side
// (master) raises we for exactly the cycles it wants a store. The accelerator
// samples we, addr and wd on every rising clock edge, and a store can never
// stall. rd is a pure combinational function of addr and the accelerator
// registers, so a load sees data in the same cycle that addr is presented.
// dbg_state mirrors the accelerator FSM state for observation only.
interface fact_accel_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic [1:0]       dbg_state;

  modport master (
    output we,
    output addr,
    output wd,
    input  rd,
    input  dbg_state
  );

  modport slave (
    input  we,
    input  addr,
    input  wd,
    output rd,
    output dbg_state
  );
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator.
// Register map: 0 = N (rw), 1 = GO (wo, reads 0), 2 = STATUS {busy, err, done},
// 3 = RESULT (ro). Each CALC cycle performs one WIDTH x WIDTH multiply and
// stops early with err set when the product no longer fits in WIDTH bits.
module fact_accel #(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  fact_accel_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_GO     = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   n_q, n_d;
  logic [N_BITS-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                wr_n;
  logic                go;
  logic [2*WIDTH-1:0]  full_prod;
  logic                prod_ovf;
  logic [WIDTH-1:0]    rd_w;

  // Only the low N_BITS of wd reach n_reg and only bit 0 matters for GO.
  logic                unused_wd;
  assign unused_wd = &{1'b0, bus.wd[WIDTH-1:N_BITS]};

  // Decode the store strobe into register writes.
  assign wr_n = bus.we && (bus.addr == A_N);
  assign go   = bus.we && (bus.addr == A_GO) && bus.wd[0];

  // Full double-width product so overflow is seen exactly, not by wraparound.
  assign full_prod = {{WIDTH{1'b0}}, prod_q}
                   * {{(2*WIDTH-N_BITS){1'b0}}, cnt_q};
  assign prod_ovf  = |full_prod[2*WIDTH-1:WIDTH];

  // Next-state and datapath control for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    busy_d   = busy_q;

    // n_reg accepts writes in every state; a running job keeps its own cnt.
    if (wr_n) begin
      n_d = bus.wd[N_BITS-1:0];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_CALC;
          cnt_d   = n_q;
          prod_d  = WIDTH'(1);
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        // GO writes are ignored here: the job in flight runs to completion.
        if (cnt_q <= N_BITS'(1)) begin
          state_d  = S_DONE;
          result_d = prod_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else if (prod_ovf) begin
          state_d  = S_DONE;
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          prod_d = full_prod[WIDTH-1:0];
          cnt_d  = cnt_q - N_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state lives here; async reset aborts any job and clears the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Read mux: combinational from addr and the registers above.
  always_comb begin
    rd_w = '0;
    case (bus.addr)
      A_N:      rd_w = {{(WIDTH-N_BITS){1'b0}}, n_q};
      A_GO:     rd_w = '0;
      A_STATUS: rd_w = {{(WIDTH-3){1'b0}}, busy_q, err_q, done_q};
      A_RESULT: rd_w = result_q;
      default:  rd_w = '0;
    endcase
  end

  assign bus.rd        = rd_w;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fact_accel.sv
// Directed bench for fact_accel: register map, latency, overflow, busy
// interference, re-run from DONE and asynchronous reset.
module tb_fact_accel;

  localparam int W = 32;

  logic clk;
  logic rst;

  fact_accel_if #(.WIDTH(W)) bus ();

  fact_accel #(.WIDTH(W), .N_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle store; returns 1 time unit after the capturing edge.
  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  // Combinational load.
  task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  // Count rising edges until done shows, bounded by budget.
  task automatic wait_done(input int budget, output int cycles);
    bus.addr = 2'd2;
    #1;
    cycles = 0;
    while (bus.rd[0] !== 1'b1 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Start a job with operand n and check latency, status and result.
  task automatic run_fact(input string tag, input logic [3:0] n,
                          input int exp_cycles, input logic [W-1:0] exp_status,
                          input logic [W-1:0] exp_res);
    logic [W-1:0] d;
    int cyc;
    exp_q.push_back(exp_res);
    bus_write(2'd0, {28'h0, n});
    bus_write(2'd1, 32'h1);
    bus_read(2'd2, d);
    check({tag, "_busy"}, d, 32'h4);
    wait_done(40, cyc);
    check({tag, "_cycles"}, W'(cyc), W'(exp_cycles));
    bus_read(2'd2, d);
    check({tag, "_status"}, d, exp_status);
    bus_read(2'd3, d);
    check({tag, "_result"}, d, exp_q.pop_front());
  endtask

  initial begin
    logic [W-1:0] d;
    int cyc;

    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.wd   = '0;
    rst      = 1'b0;

    // Reset values are visible while reset is held.
    #2;
    bus_read(2'd0, d); check("rst_n", d, 32'h0);
    bus_read(2'd2, d); check("rst_status", d, 32'h0);
    bus_read(2'd3, d); check("rst_result", d, 32'h0);
    check("rst_state", W'(bus.dbg_state), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // N write keeps only the low bits; GO reads 0.
    bus_write(2'd0, 32'hFFFF_FFF7);
    bus_read(2'd0, d); check("n_zext", d, 32'h7);
    bus_read(2'd1, d); check("go_read", d, 32'h0);

    // Basic N=5: RESULT stays 0 while computing, done after 5 edges.
    bus_write(2'd0, 32'h5);
    bus_write(2'd1, 32'h1);
    bus_read(2'd3, d); check("n5_result_calc", d, 32'h0);
    bus_read(2'd2, d); check("n5_busy", d, 32'h4);
    wait_done(40, cyc);
    check("n5_cycles", W'(cyc), 32'd5);
    bus_read(2'd2, d); check("n5_status", d, 32'h1);
    bus_read(2'd3, d); check("n5_result", d, 32'd120);

    // Edge operands.
    run_fact("n0",  4'd0,  1,  32'h1, 32'd1);
    run_fact("n1",  4'd1,  1,  32'h1, 32'd1);
    run_fact("n12", 4'd12, 12, 32'h1, 32'h1C8C_FC00);
    // 13!: the twelfth multiply (x2) overflows, so err lands at edge 12.
    run_fact("n13", 4'd13, 12, 32'h3, 32'h0);

    // Busy interference: N and GO writes during CALC.
    bus_write(2'd0, 32'h6);
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'h3);
    bus_write(2'd1, 32'h1);
    bus_read(2'd2, d); check("bi_busy", d, 32'h4);
    bus_read(2'd0, d); check("bi_n_new", d, 32'h3);
    wait_done(40, cyc);
    bus_read(2'd2, d); check("bi_status", d, 32'h1);
    bus_read(2'd3, d); check("bi_result", d, 32'd720);
    bus_write(2'd1, 32'h1);
    wait_done(40, cyc);
    check("bi_cycles", W'(cyc), 32'd3);
    bus_read(2'd3, d); check("bi_result2", d, 32'd6);
    bus_read(2'd0, d); check("bi_n_after", d, 32'h3);

    // Re-run from DONE: done drops on the start edge, old result held.
    run_fact("n4", 4'd4, 4, 32'h1, 32'd24);
    bus_write(2'd1, 32'h1);
    bus_read(2'd2, d); check("rerun_status_start", d, 32'h4);
    bus_read(2'd3, d); check("rerun_result_calc", d, 32'd24);
    wait_done(40, cyc);
    check("rerun_cycles", W'(cyc), 32'd4);
    bus_read(2'd3, d); check("rerun_result", d, 32'd24);

    // Non-starting and read-only writes change nothing.
    bus_write(2'd1, 32'h2);
    check("go_bit0_clear_state", W'(bus.dbg_state), 32'h2);
    bus_read(2'd2, d); check("go_bit0_clear_status", d, 32'h1);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd2, d); check("ro_status", d, 32'h1);
    bus_read(2'd3, d); check("ro_result", d, 32'd24);

    // Reset in the middle of N=9.
    bus_write(2'd0, 32'h9);
    bus_write(2'd1, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_calc", W'(bus.dbg_state), 32'h1);
    rst = 1'b0;
    #1;
    bus_read(2'd2, d); check("mid_rst_status", d, 32'h0);
    bus_read(2'd3, d); check("mid_rst_result", d, 32'h0);
    bus_read(2'd0, d); check("mid_rst_n", d, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_state", W'(bus.dbg_state), 32'h0);
    bus_read(2'd2, d); check("post_rst_status", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
